time_base_gen: RTL and testbench
================================

# time_base_gen

Time-base generator for the timer subsystem. It divides the `clk_50m` system clock into single-cycle `one_sec_timer`, `one_min_timer` and `one_hour_timer` strobes, and keeps running seconds/minutes/hours counts. It sits directly upstream of the LED controller, which consumes the three strobes. An optional load path presets the time of day.

## Interface
- `CLK_FREQ_HZ`, 50_000_000 — clock cycles per second; prescaler width is `$clog2(CLK_FREQ_HZ)`.
- `SEC_PER_MIN`, 60 — seconds per minute.
- `MIN_PER_HOUR`, 60 — minutes per hour.
- `HOUR_PER_DAY`, 24 — hours per day.
- `clk_50m`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = count, 0 = hold all counters and suppress strobes.
- `clear`  in  1  synchronous clear of prescaler and all counts.
- `load`  in  1  synchronous preset strobe (`TIME_LOAD_EN` only).
- `load_sec`  in  6  preset seconds value (`TIME_LOAD_EN` only).
- `load_min`  in  6  preset minutes value (`TIME_LOAD_EN` only).
- `load_hour`  in  5  preset hours value (`TIME_LOAD_EN` only).
- `one_sec_timer`  out  1  one-cycle strobe, once per second.
- `one_min_timer`  out  1  one-cycle strobe, once per minute.
- `one_hour_timer`  out  1  one-cycle strobe, once per hour.
- `sec_count`  out  6  current seconds, 0..SEC_PER_MIN-1.
- `min_count`  out  6  current minutes, 0..MIN_PER_HOUR-1.
- `hour_count`  out  5  current hours, 0..HOUR_PER_DAY-1.

## Operation
- **Reset:** every output and the prescaler go to 0 immediately when `reset` asserts, independent of the clock.
- **Priority**, evaluated each edge: `reset` > `clear` > `load` > `run`.
- **Clear:** prescaler and all counts are set to 0. No strobe is asserted in the following cycle.
- **Prescaler:** when `run`=1, it counts 0..CLK_FREQ_HZ-1 and wraps to 0. When `run`=0, it holds its value; it is not reset.
- **Second tick:** on the edge where the prescaler wraps, `sec_count` increments and `one_sec_timer` is registered high for exactly one cycle.
- **Seconds wrap:** `sec_count` wraps from SEC_PER_MIN-1 to 0. On that same edge `min_count` increments and `one_min_timer` is asserted, coincident with that `one_sec_timer`.
- **Minutes wrap:** `min_count` wraps from MIN_PER_HOUR-1 to 0. On that same edge `hour_count` increments and `one_hour_timer` is asserted, coincident with the minute and second strobes.
- **Hours wrap:** `hour_count` wraps from HOUR_PER_DAY-1 to 0. No day strobe is produced.
- **Strobes:** all three are registered outputs. None of them is ever high for two consecutive cycles.
- **Arithmetic:** counters use width-exact unsigned compare-and-wrap. No counter ever holds a value at or above its limit.

## Timing
- With `run` held at 1 from reset release, the first `one_sec_timer` is high in cycle CLK_FREQ_HZ, counting the first active edge as cycle 1. Subsequent strobes follow every CLK_FREQ_HZ cycles.
- `run` low for N cycles delays every later strobe by exactly N cycles.
- Counts update on the same edge that raises the corresponding strobe. The LED controller sees the new count during the strobe cycle.
- Reset asserted mid-second: outputs are 0 asynchronously. After release, counting restarts from prescaler 0.

## Configuration
- **Macro:** `TIME_LOAD_EN`.
- **Defined:** the `load`, `load_sec`, `load_min` and `load_hour` ports exist.
  - When `load`=1 and `clear`=0, the counts take the load values and the prescaler goes to 0. No strobe is asserted in the next cycle.
  - Any field at or above its limit loads as 0.
  - Loading is independent of `run`.
- **Undefined:** the load ports and load logic are absent, and counts start only from reset or `clear`.

## Test plan
- **Basic second rate:** CLK_FREQ_HZ=10, reset, then `run`=1 → `one_sec_timer` high in cycles 10, 20, 30; `sec_count`=1, 2, 3 at each strobe; the other two strobes stay low.
- **Minute rollover:** CLK_FREQ_HZ=10, run 600 cycles → `one_min_timer` high together with the 60th `one_sec_timer`; then `sec_count`=0 and `min_count`=1.
- **Hour/day wrap:** `TIME_LOAD_EN`, load 23:59:59 → 10 cycles later all three strobes are high in the same cycle and all counts are 0.
- **Run hold:** drop `run` at prescaler 5 for 7 cycles → the next `one_sec_timer` arrives 7 cycles late and the counts are unchanged during the hold.
- **Priority and reset:** assert `clear` and `load` together → all counts 0. Assert `reset` mid-second → all outputs 0 before the next edge.
- **Out-of-range load:** `TIME_LOAD_EN`, load `sec`=60, `min`=61, `hour`=24 → all counts load as 0 with no strobes.

Source files
------------

// File: rtl/time_base_gen_if.sv
// Bus between the time-base generator and its users: run/clear controls,
// optional time-of-day preset (TIME_LOAD_EN), strobes and running counts.
interface time_base_gen_if;
    logic       run;
    logic       clear;
`ifdef TIME_LOAD_EN
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
`endif
    logic       one_sec_timer;
    logic       one_min_timer;
    logic       one_hour_timer;
    logic [5:0] sec_count;
    logic [5:0] min_count;
    logic [4:0] hour_count;

`ifdef TIME_LOAD_EN
    modport master (
        output run, clear, load, load_sec, load_min, load_hour,
        input  one_sec_timer, one_min_timer, one_hour_timer,
               sec_count, min_count, hour_count
    );
    modport slave (
        input  run, clear, load, load_sec, load_min, load_hour,
        output one_sec_timer, one_min_timer, one_hour_timer,
               sec_count, min_count, hour_count
    );
`else
    modport master (
        output run, clear,
        input  one_sec_timer, one_min_timer, one_hour_timer,
               sec_count, min_count, hour_count
    );
    modport slave (
        input  run, clear,
        output one_sec_timer, one_min_timer, one_hour_timer,
               sec_count, min_count, hour_count
    );
`endif
endinterface

// File: rtl/time_base_gen.sv
// Time-base generator: divides clk_50m into one-cycle second/minute/hour
// strobes and keeps seconds/minutes/hours of day.
// Optional feature macro: TIME_LOAD_EN adds the synchronous time-of-day preset.
module time_base_gen #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int SEC_PER_MIN  = 60,
    parameter int MIN_PER_HOUR = 60,
    parameter int HOUR_PER_DAY = 24
) (
    input  logic           clk_50m,
    input  logic           reset,
    time_base_gen_if.slave bus
);
    // Keep a legal width even for a degenerate 1 Hz clock.
    localparam int              PW        = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(CLK_FREQ_HZ - 1);
    localparam logic [PW-1:0]   PRE_ONE   = PW'(1);
    localparam logic [5:0]      SEC_LAST  = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0]      MIN_LAST  = 6'(MIN_PER_HOUR - 1);
    localparam logic [4:0]      HOUR_LAST = 5'(HOUR_PER_DAY - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hour;
    logic          r_sec_stb;
    logic          r_min_stb;
    logic          r_hour_stb;

    logic [PW-1:0] w_presc_next;
    logic [5:0]    w_sec_next;
    logic [5:0]    w_min_next;
    logic [4:0]    w_hour_next;
    logic          w_sec_stb_next;
    logic          w_min_stb_next;
    logic          w_hour_stb_next;

    logic          w_presc_wrap;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic          w_hour_wrap;

    assign w_presc_wrap = (r_presc == PRE_LAST);
    assign w_sec_wrap   = (r_sec   == SEC_LAST);
    assign w_min_wrap   = (r_min   == MIN_LAST);
    assign w_hour_wrap  = (r_hour  == HOUR_LAST);

`ifdef TIME_LOAD_EN
    // Out-of-range preset fields are forced to zero so a count never
    // holds a value at or above its limit.
    logic [5:0] w_load_sec;
    logic [5:0] w_load_min;
    logic [4:0] w_load_hour;

    assign w_load_sec  = ({1'b0, bus.load_sec}  >= 7'(SEC_PER_MIN))  ? 6'd0 : bus.load_sec;
    assign w_load_min  = ({1'b0, bus.load_min}  >= 7'(MIN_PER_HOUR)) ? 6'd0 : bus.load_min;
    assign w_load_hour = ({1'b0, bus.load_hour} >= 6'(HOUR_PER_DAY)) ? 5'd0 : bus.load_hour;
`endif

    // Next-state: clear beats load beats run; strobes default low so none
    // can stay high past the edge that raised it.
    always_comb begin
        w_presc_next    = r_presc;
        w_sec_next      = r_sec;
        w_min_next      = r_min;
        w_hour_next     = r_hour;
        w_sec_stb_next  = 1'b0;
        w_min_stb_next  = 1'b0;
        w_hour_stb_next = 1'b0;
        if (bus.clear) begin
            w_presc_next = '0;
            w_sec_next   = '0;
            w_min_next   = '0;
            w_hour_next  = '0;
        end
`ifdef TIME_LOAD_EN
        else if (bus.load) begin
            w_presc_next = '0;
            w_sec_next   = w_load_sec;
            w_min_next   = w_load_min;
            w_hour_next  = w_load_hour;
        end
`endif
        else if (bus.run) begin
            if (w_presc_wrap) begin
                w_presc_next   = '0;
                w_sec_stb_next = 1'b1;
                if (w_sec_wrap) begin
                    w_sec_next     = '0;
                    w_min_stb_next = 1'b1;
                    if (w_min_wrap) begin
                        w_min_next      = '0;
                        w_hour_stb_next = 1'b1;
                        w_hour_next     = w_hour_wrap ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        w_min_next = r_min + 6'd1;
                    end
                end else begin
                    w_sec_next = r_sec + 6'd1;
                end
            end else begin
                w_presc_next = r_presc + PRE_ONE;
            end
        end
    end

    // State and registered strobes; reset clears everything immediately.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_sec_stb  <= 1'b0;
            r_min_stb  <= 1'b0;
            r_hour_stb <= 1'b0;
        end else begin
            r_presc    <= w_presc_next;
            r_sec      <= w_sec_next;
            r_min      <= w_min_next;
            r_hour     <= w_hour_next;
            r_sec_stb  <= w_sec_stb_next;
            r_min_stb  <= w_min_stb_next;
            r_hour_stb <= w_hour_stb_next;
        end
    end

    assign bus.one_sec_timer  = r_sec_stb;
    assign bus.one_min_timer  = r_min_stb;
    assign bus.one_hour_timer = r_hour_stb;
    assign bus.sec_count      = r_sec;
    assign bus.min_count      = r_min;
    assign bus.hour_count     = r_hour;
endmodule

// File: tb/tb_time_base_gen.sv
// Testbench for time_base_gen with a 10-cycle second. The reference model
// tracks elapsed time of day in whole seconds plus a cycle prescaler.
module tb_time_base_gen;
    localparam int F   = 10;
    localparam int SPM = 60;
    localparam int MPH = 60;
    localparam int HPD = 24;
    localparam int DAY = SPM * MPH * HPD;

    logic clk_50m = 1'b0;
    logic reset   = 1'b1;

    time_base_gen_if bus();

    time_base_gen #(
        .CLK_FREQ_HZ (F),
        .SEC_PER_MIN (SPM),
        .MIN_PER_HOUR(MPH),
        .HOUR_PER_DAY(HPD)
    ) dut (
        .clk_50m(clk_50m),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_50m = ~clk_50m;

    int   checks = 0;
    int   errors = 0;
    int   cyc;          // active edges since reset release
    int   m_presc;      // model cycles into the current second
    int   m_tod;        // model time of day in seconds
    logic m_s, m_m, m_h;

    function automatic logic [19:0] exp_vec();
        return {m_s, m_m, m_h,
                6'(m_tod % SPM),
                6'((m_tod / SPM) % MPH),
                5'(m_tod / (SPM * MPH))};
    endfunction

    function automatic logic [19:0] act_vec();
        return {bus.one_sec_timer, bus.one_min_timer, bus.one_hour_timer,
                bus.sec_count, bus.min_count, bus.hour_count};
    endfunction

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_edge();
        m_s = 1'b0; m_m = 1'b0; m_h = 1'b0;
        if (bus.clear) begin
            m_presc = 0;
            m_tod   = 0;
        end
`ifdef TIME_LOAD_EN
        else if (bus.load) begin
            int ls, lm, lh;
            ls = (int'(bus.load_sec)  >= SPM) ? 0 : int'(bus.load_sec);
            lm = (int'(bus.load_min)  >= MPH) ? 0 : int'(bus.load_min);
            lh = (int'(bus.load_hour) >= HPD) ? 0 : int'(bus.load_hour);
            m_presc = 0;
            m_tod   = lh * SPM * MPH + lm * SPM + ls;
        end
`endif
        else if (bus.run) begin
            m_presc++;
            if (m_presc == F) begin
                m_presc = 0;
                m_tod   = (m_tod + 1) % DAY;
                m_s     = 1'b1;
                m_m     = (m_tod % SPM) == 0;
                m_h     = (m_tod % (SPM * MPH)) == 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.run   = 1'b0;
        bus.clear = 1'b0;
`ifdef TIME_LOAD_EN
        bus.load      = 1'b0;
        bus.load_sec  = '0;
        bus.load_min  = '0;
        bus.load_hour = '0;
`endif
    endtask

    // Assert reset between edges, hold across one edge, release between edges.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        m_presc = 0; m_tod = 0; m_s = 0; m_m = 0; m_h = 0;
        @(posedge clk_50m);
        #2;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (act_vec() !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), 20'd0);
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_cyc%0d: got %h expected %h", cyc, act_vec(), exp_vec());
            end
            checks++;
            if (bus.one_sec_timer !== ((cyc % 10) == 0) ||
                bus.one_min_timer !== 1'b0 || bus.one_hour_timer !== 1'b0 ||
                int'(bus.sec_count) !== cyc / 10) begin
                errors++;
                $display("FAIL basic_rate_cyc%0d: got sec_stb=%b min_stb=%b hour_stb=%b sec=%0d expected sec_stb=%b 0 0 sec=%0d",
                         cyc, bus.one_sec_timer, bus.one_min_timer, bus.one_hour_timer,
                         bus.sec_count, (cyc % 10) == 0, cyc / 10);
            end
        end
        $display("test_basic done cycles=%0d", cyc);
    endtask

    task automatic test_minute();
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 605; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL minute_cyc%0d: got %h expected %h", cyc, act_vec(), exp_vec());
            end
            if (cyc == 600) begin
                checks++;
                if (bus.one_min_timer !== 1'b1 || bus.one_sec_timer !== 1'b1 ||
                    bus.sec_count !== 6'd0 || bus.min_count !== 6'd1) begin
                    errors++;
                    $display("FAIL minute_rollover: got sec_stb=%b min_stb=%b sec=%0d min=%0d expected 1 1 0 1",
                             bus.one_sec_timer, bus.one_min_timer, bus.sec_count, bus.min_count);
                end
            end
        end
        $display("test_minute done cycles=%0d", cyc);
    endtask

    task automatic test_run_hold();
        int first;
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (act_vec() !== 20'd0 || act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_cyc%0d: got %h expected %h", cyc, act_vec(), exp_vec());
            end
        end
        bus.run = 1'b1;
        first = -1;
        for (int i = 0; i < 30 && first < 0; i++) begin
            tick();
            if (bus.one_sec_timer === 1'b1) first = cyc;
        end
        checks++;
        if (first != 17) begin
            errors++;
            $display("FAIL hold_delay: got first strobe at cycle %0d expected 17", first);
        end
        $display("test_run_hold done");
    endtask

    task automatic test_priority();
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 23; i++) tick();
        bus.clear = 1'b1;
`ifdef TIME_LOAD_EN
        bus.load      = 1'b1;
        bus.load_sec  = 6'd12;
        bus.load_min  = 6'd34;
        bus.load_hour = 5'd5;
`endif
        tick();
        checks++;
        if (act_vec() !== 20'd0) begin
            errors++;
            $display("FAIL clear_priority: got %h expected %h", act_vec(), 20'd0);
        end
        idle_inputs();
        bus.run = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (bus.sec_count !== 6'd1) begin
            errors++;
            $display("FAIL after_clear: got sec=%0d expected 1", bus.sec_count);
        end
        // Mid-second asynchronous reset: outputs must drop before any edge.
        reset = 1'b1;
        #1;
        checks++;
        if (act_vec() !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), 20'd0);
        end
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.one_sec_timer !== 1'b1 || bus.sec_count !== 6'd1) begin
            errors++;
            $display("FAIL restart_after_reset: got sec_stb=%b sec=%0d expected 1 1",
                     bus.one_sec_timer, bus.sec_count);
        end
        $display("test_priority done");
    endtask

`ifdef TIME_LOAD_EN
    task automatic test_load();
        do_reset();
        bus.load = 1'b1; bus.load_sec = 6'd59; bus.load_min = 6'd59; bus.load_hour = 5'd23;
        tick();
        bus.load = 1'b0;
        bus.run  = 1'b1;
        checks++;
        if (act_vec() !== {3'b000, 6'd59, 6'd59, 5'd23}) begin
            errors++;
            $display("FAIL load_2359: got %h expected %h", act_vec(), {3'b000, 6'd59, 6'd59, 5'd23});
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (act_vec() !== {3'b111, 6'd0, 6'd0, 5'd0}) begin
            errors++;
            $display("FAIL day_wrap: got %h expected %h", act_vec(), {3'b111, 6'd0, 6'd0, 5'd0});
        end
        bus.load = 1'b1; bus.load_sec = 6'd60; bus.load_min = 6'd61; bus.load_hour = 5'd24;
        tick();
        bus.load = 1'b0;
        checks++;
        if (act_vec() !== 20'd0) begin
            errors++;
            $display("FAIL bad_load: got %h expected %h", act_vec(), 20'd0);
        end
        $display("test_load done");
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bus.run   = ($urandom_range(0, 9) != 0);
            bus.clear = ($urandom_range(0, 299) == 0);
`ifdef TIME_LOAD_EN
            bus.load      = ($urandom_range(0, 59) == 0);
            bus.load_sec  = 6'($urandom_range(50, 63));
            bus.load_min  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(56, 63)) : 6'($urandom_range(0, 63));
            bus.load_hour = 5'($urandom_range(20, 31));
`endif
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cyc%0d: got %h expected %h", cyc, act_vec(), exp_vec());
            end
        end
        idle_inputs();
        $display("test_random done cycles=%0d", cyc);
    endtask

    initial begin
        idle_inputs();
        cyc = 0;
        test_reset();
        test_basic();
        test_minute();
        test_run_hold();
        test_priority();
`ifdef TIME_LOAD_EN
        test_load();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
